// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - byte sequencer between uart_rx/uart_tx and a combinational ALU
//
// Purpose:
//   Collects operand A, operand B and the opcode as three consecutive received
//   bytes. Drives them as registered operands into the ALU, captures the ALU
//   result one cycle later and hands it to the UART transmitter with a
//   start/done handshake.
//
// Optional feature (macro ALU_CARRY_TX_EN):
//   When defined, a second byte carrying the ALU carry in bit 0 is transmitted
//   after the result byte (states SEND_CY/WAIT_CY and the carry register exist).
//   When undefined, only the result byte is sent and the carry is ignored.
//
// Parameters:
//   SIZEDATA  operand/result width, equal to the UART byte width
//   SIZEOP    opcode width, must not exceed SIZEDATA
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       synchronous active-high reset
//   rx_data_i     received byte
//   rx_valid_i    one-cycle pulse, rx_data_i valid
//   alu_result_i  ALU result
//   alu_carry_i   ALU carry
//   tx_done_i     one-cycle pulse, transmitter finished the current byte
//   datoa_o       operand A to ALU (registered)
//   datob_o       operand B to ALU (registered)
//   opcode_o      opcode to ALU (registered)
//   tx_data_o     byte to transmit (registered)
//   tx_start_o    one-cycle pulse, start sending tx_data_o (registered)
//   busy_o        high whenever the sequencer is not waiting for operand A

module alu_uart_sequencer #(
   parameter int SIZEDATA = 8,
   parameter int SIZEOP   = 6
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [SIZEDATA-1:0] rx_data_i,
   input  logic                rx_valid_i,
   input  logic [SIZEDATA-1:0] alu_result_i,
   input  logic                alu_carry_i,
   input  logic                tx_done_i,
   output logic [SIZEDATA-1:0] datoa_o,
   output logic [SIZEDATA-1:0] datob_o,
   output logic [SIZEOP-1:0]   opcode_o,
   output logic [SIZEDATA-1:0] tx_data_o,
   output logic                tx_start_o,
   output logic                busy_o
);

   typedef enum logic [2:0] {
      ST_GET_A    = 3'd0,
      ST_GET_B    = 3'd1,
      ST_GET_OP   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_SEND_RES = 3'd4,
`ifdef ALU_CARRY_TX_EN
      ST_WAIT_RES = 3'd5,
      ST_SEND_CY  = 3'd6,
      ST_WAIT_CY  = 3'd7
`else
      ST_WAIT_RES = 3'd5
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [SIZEDATA-1:0] datoa_q, datoa_d;
   logic [SIZEDATA-1:0] datob_q, datob_d;
   logic [SIZEOP-1:0]   opcode_q, opcode_d;
   logic [SIZEDATA-1:0] tx_data_q, tx_data_d;
   logic                tx_start_q, tx_start_d;

`ifdef ALU_CARRY_TX_EN
   logic                carry_q, carry_d;
`else
   // Carry is not transmitted in this build; the input is deliberately unused.
   logic                unused_carry;
   assign unused_carry = alu_carry_i;
`endif

   // Next-state and datapath-load logic. tx_start is computed for the state
   // being entered so that the registered pulse coincides exactly with the
   // SEND_* state it belongs to.
   always_comb begin
      state_d    = state_q;
      datoa_d    = datoa_q;
      datob_d    = datob_q;
      opcode_d   = opcode_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
`ifdef ALU_CARRY_TX_EN
      carry_d    = carry_q;
`endif

      case (state_q)
         ST_GET_A: begin
            if (rx_valid_i) begin
               datoa_d = rx_data_i;
               state_d = ST_GET_B;
            end
         end

         ST_GET_B: begin
            if (rx_valid_i) begin
               datob_d = rx_data_i;
               state_d = ST_GET_OP;
            end
         end

         ST_GET_OP: begin
            if (rx_valid_i) begin
               // Upper bits of the opcode byte are dropped.
               opcode_d = rx_data_i[SIZEOP-1:0];
               state_d  = ST_EXEC;
            end
         end

         ST_EXEC: begin
            // Operands have been stable at the ALU for a full cycle here.
            tx_data_d  = alu_result_i;
`ifdef ALU_CARRY_TX_EN
            carry_d    = alu_carry_i;
`endif
            tx_start_d = 1'b1;
            state_d    = ST_SEND_RES;
         end

         ST_SEND_RES: begin
            state_d = ST_WAIT_RES;
         end

         ST_WAIT_RES: begin
            if (tx_done_i) begin
`ifdef ALU_CARRY_TX_EN
               tx_data_d  = {{(SIZEDATA-1){1'b0}}, carry_q};
               tx_start_d = 1'b1;
               state_d    = ST_SEND_CY;
`else
               state_d    = ST_GET_A;
`endif
            end
         end

`ifdef ALU_CARRY_TX_EN
         ST_SEND_CY: begin
            state_d = ST_WAIT_CY;
         end

         ST_WAIT_CY: begin
            if (tx_done_i) begin
               state_d = ST_GET_A;
            end
         end
`endif

         default: begin
            state_d = ST_GET_A;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_GET_A;
         datoa_q    <= '0;
         datob_q    <= '0;
         opcode_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
`ifdef ALU_CARRY_TX_EN
         carry_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         datoa_q    <= datoa_d;
         datob_q    <= datob_d;
         opcode_q   <= opcode_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
`ifdef ALU_CARRY_TX_EN
         carry_q    <= carry_d;
`endif
      end
   end

   assign datoa_o    = datoa_q;
   assign datob_o    = datob_q;
   assign opcode_o   = opcode_q;
   assign tx_data_o  = tx_data_q;
   assign tx_start_o = tx_start_q;
   assign busy_o     = (state_q != ST_GET_A);

endmodule
